dspl_scan_driver: RTL and testbench
===================================

# dspl_scan_driver

Time-multiplexed eight-digit seven-segment scan driver, downstream of the counter stage in the counter/display datapath. It consumes a 32-bit value (eight hex nibbles), a per-digit decimal-point mask and control flags. It drives the active-low segment lines `dspl_a`..`dspl_g`, `dspl_p` and anodes `dspl_an`, refreshing one digit every `HALF_MS_COUNT` clocks. The value is snapshotted once per frame so a changing counter never tears the displayed number.

## Interface
- `HALF_MS_COUNT`, 50000: clocks per digit slot (0.5 ms at 100 MHz); legal range ≥ 2.
- `NUM_DIGITS`, 8: digits scanned; fixed at 8 in this revision.
- `clk_i`  in  1  system clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `value_i`  in  32  value to display; nibble k → digit k (digit 0 rightmost).
- `dp_i`  in  8  decimal point request per digit, 1 = lit.
- `blank_lz_i`  in  1  1 = blank leading-zero digits.
- `en_i`  in  1  0 = display dark (all anodes and segments off).
- `dspl_a`..`dspl_g`, `dspl_p`  out  1 each  segment/point, active-low, registered.
- `dspl_an`  out  8  digit anodes, active-low one-hot, registered.

## Operation
- Prescaler `pre` counts 0..HALF_MS_COUNT-1 and wraps. `tick` = (`pre` == HALF_MS_COUNT-1).
- Digit index `idx` (3 bits) advances on `tick` and wraps 7→0. Reset value of `idx` is 7, so the first tick enters digit 0.
- Frame boundary is a `tick` with `idx`==7:
  - `snap` ← `value_i` and `dp_snap` ← `dp_i`.
  - `blank_mask` is computed from `value_i`. Bit k = 1 when `blank_lz_i`=1, k≥1, and nibbles k..7 are all zero. Digit 0 is never blanked.
- On every `tick`, the output registers load the digit for the next index. At a frame boundary the decode uses `value_i`/`dp_i` directly (same values being snapshotted). Otherwise it uses `snap`/`dp_snap`.
- Segment map `{g,f,e,d,c,b,a}`, active-low, hex 0–F standard (0=7'b1000000, 1=7'b1111001, 7=7'b1111000, 8=7'b0000000, A=7'b0001000, F=7'b0001110).
- Blanked digit: anode still driven low, segments all 1. `dspl_p` still follows the dp mask.
- `en_i`=0:
  - Next loaded outputs are all 1 (`dspl_an`=8'hFF).
  - Prescaler, `idx` and snapshots keep running, so re-enabling resumes in phase.
- Reset (async, any time):
  - `pre`=0, `idx`=7, `snap`=0, `dp_snap`=0, `blank_mask`=0.
  - All segment outputs = 1, `dspl_an`=8'hFF.
  - Values take effect immediately, without a clock edge.
- Inputs sampled only at ticks. Changes between ticks have no effect on outputs.

## Timing
- Outputs change only on the clock edge ending a `tick` cycle. Each digit is displayed for exactly HALF_MS_COUNT cycles; one frame = 8·HALF_MS_COUNT cycles.
- After reset release: outputs stay dark for HALF_MS_COUNT edges. On edge HALF_MS_COUNT, `dspl_an` becomes 8'hFE showing digit 0 of `value_i` sampled on that edge.
- Latency from a `value_i` change to display: it appears at the next frame boundary, ≤ 8·HALF_MS_COUNT cycles.
- `en_i` and `blank_lz_i` take effect at the next tick. `blank_lz_i` is latched only at frame boundaries, together with the mask.
- Anode and segment changes occur on the same edge (single register stage). No overlap or ghost cycle.

## Structure
- Package `dspl_pkg`:
  - `NUM_DIGITS` constant.
  - `SEG_BLANK` = 7'h7F.
  - `seg7_t` typedef (7-bit).
  - Function `hex2seg(nibble) → seg7_t` with the table above.
- Sub-module `hex7seg` (combinational wrapper of `hex2seg`), instantiated once on the selected nibble.
- Everything else (prescaler, index, snapshot, blank mask, output regs) stays in `dspl_scan_driver`.

## Test plan
Bench uses HALF_MS_COUNT=5 and a 10 ns clock.
- Reset: `rst_ni`=0 asserted mid-cycle → all `dspl_*`=1 and `dspl_an`=8'hFF before the next edge. Release → dark for 5 edges, then `dspl_an`=8'hFE.
- `value_i`=32'h1234_5678, `blank_lz_i`=0, `en_i`=1:
  - Digit 0: `dspl_an`=8'hFE, segments 7'b0000000 ('8').
  - 5 cycles later: `dspl_an`=8'hFD, 7'b1111000 ('7').
  - Continues through 8'h7F showing '1', then wraps to 8'hFE.
- Anti-tear: switch `value_i` to 32'hFFFF_FFFF while `dspl_an`=8'hF7 → digits 4–7 still show 4,3,2,1. Next frame digit 0 shows 7'b0001110 ('F').
- Leading-zero blanking, `blank_lz_i`=1:
  - `value_i`=32'h0000_00A0 → digit 0 '0', digit 1 'A', digits 2–7 segments 7'h7F.
  - `value_i`=0 → only digit 0 shows '0'.
- `dp_i`=8'h04 → `dspl_p`=0 only while `dspl_an`=8'hFB, 1 elsewhere.
- `en_i`=0 for one frame → `dspl_an`=8'hFF throughout. Re-enable at a tick → scan resumes at the index it would have reached, with no extra delay.

Source files
------------

// File: rtl/dspl_pkg.sv
// rtl/dspl_pkg.sv - shared constants, types and hex-to-segment decode for the scan driver
package dspl_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [6:0] seg7_t;  // {g,f,e,d,c,b,a}, active-low

  localparam seg7_t SEG_BLANK = 7'h7F;

  function automatic seg7_t hex2seg(input logic [3:0] nibble);
    seg7_t seg;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational hex nibble to active-low seven-segment pattern
module hex7seg
  import dspl_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg7_t      seg_o
);

  assign seg_o = hex2seg(nibble_i);

endmodule

// File: rtl/dspl_scan_driver.sv
// rtl/dspl_scan_driver.sv - eight-digit multiplexed seven-segment driver with per-frame snapshot
module dspl_scan_driver
  import dspl_pkg::*;
#(
  parameter int HALF_MS_COUNT = 50000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] value_i,
  input  logic [7:0]  dp_i,
  input  logic        blank_lz_i,
  input  logic        en_i,
  output logic        dspl_a,
  output logic        dspl_b,
  output logic        dspl_c,
  output logic        dspl_d,
  output logic        dspl_e,
  output logic        dspl_f,
  output logic        dspl_g,
  output logic        dspl_p,
  output logic [7:0]  dspl_an
);

  localparam int PW = (HALF_MS_COUNT > 2) ? $clog2(HALF_MS_COUNT) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(HALF_MS_COUNT - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   snap_q;
  logic [7:0]    dp_snap_q;
  logic [7:0]    blank_mask_q;
  seg7_t         seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [7:0]    an_q, an_d;

  logic          tick, frame;
  logic [7:0]    lz_mask;
  logic          zero_above;
  logic [31:0]   sel_val;
  logic [7:0]    sel_dp, sel_blank;
  logic [3:0]    nibble;
  seg7_t         hex_seg;

  assign tick  = (pre_q == PRE_MAX);
  assign frame = tick && (idx_q == 3'd7);
  assign idx_d = idx_q + 3'd1;

  // A digit blanks only if it and every more significant nibble are zero.
  always_comb begin
    lz_mask    = '0;
    zero_above = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (value_i[4*k +: 4] == 4'h0);
      lz_mask[k] = blank_lz_i & zero_above;
    end
  end

  // At the frame boundary decode the live inputs, which are the ones being snapshotted.
  assign sel_val   = frame ? value_i : snap_q;
  assign sel_dp    = frame ? dp_i    : dp_snap_q;
  assign sel_blank = frame ? lz_mask : blank_mask_q;
  assign nibble    = sel_val[{idx_d, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nibble_i (nibble),
    .seg_o    (hex_seg)
  );

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    an_d  = 8'hFF;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (en_i) begin
      an_d  = ~(8'h01 << idx_d);
      seg_d = sel_blank[idx_d] ? SEG_BLANK : hex_seg;
      dp_d  = ~sel_dp[idx_d];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q        <= '0;
      idx_q        <= 3'd7;
      snap_q       <= '0;
      dp_snap_q    <= '0;
      blank_mask_q <= '0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      an_q         <= 8'hFF;
    end else begin
      pre_q <= pre_d;
      if (tick) begin
        idx_q <= idx_d;
        seg_q <= seg_d;
        dp_q  <= dp_d;
        an_q  <= an_d;
      end
      if (frame) begin
        snap_q       <= value_i;
        dp_snap_q    <= dp_i;
        blank_mask_q <= lz_mask;
      end
    end
  end

  assign {dspl_g, dspl_f, dspl_e, dspl_d, dspl_c, dspl_b, dspl_a} = seg_q;
  assign dspl_p  = dp_q;
  assign dspl_an = an_q;

endmodule

// File: tb/tb_dspl_scan_driver.sv
// tb/tb_dspl_scan_driver.sv - table-driven bench for dspl_scan_driver
module tb_dspl_scan_driver;

  localparam int HMS = 5;

  typedef struct {
    logic [31:0] value;
    logic [7:0]  dp;
    logic        blz;
    logic        en;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        p;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] value;
  logic [7:0]  dp;
  logic        blz;
  logic        en;
  logic        sa, sb, sc, sd, se, sf, sg, sp;
  logic [7:0]  an;

  int n_vec;
  int n_err;
  vec_t vecs[$];
  vec_t prev;

  dspl_scan_driver #(.HALF_MS_COUNT(HMS)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .value_i    (value),
    .dp_i       (dp),
    .blank_lz_i (blz),
    .en_i       (en),
    .dspl_a     (sa),
    .dspl_b     (sb),
    .dspl_c     (sc),
    .dspl_d     (sd),
    .dspl_e     (se),
    .dspl_f     (sf),
    .dspl_g     (sg),
    .dspl_p     (sp),
    .dspl_an    (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] hs(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [7:0] anode(input int k);
    return ~(8'h01 << k);
  endfunction

  task automatic add(input logic [31:0] v, input logic [7:0] d, input logic b, input logic e,
                     input logic [7:0] a, input logic [6:0] s, input logic p);
    vec_t t;
    t.value = v; t.dp = d; t.blz = b; t.en = e; t.an = a; t.seg = s; t.p = p;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [7:0] ea, input logic [6:0] es, input logic ep);
    logic [6:0] seg;
    seg = {sg, sf, se, sd, sc, sb, sa};
    n_vec++;
    if (an !== ea || seg !== es || sp !== ep) begin
      n_err++;
      $display("FAIL %s: got an=%h seg=%b p=%b, expected an=%h seg=%b p=%b",
               name, an, seg, sp, ea, es, ep);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    value = '0;
    dp    = '0;
    blz   = 1'b0;
    en    = 1'b1;

    // frame A: plain scan of 1234_5678
    for (int k = 0; k < 8; k++) add(32'h1234_5678, 8'h00, 1'b0, 1'b1, anode(k), hs(8 - k), 1'b1);
    // frame B: value changes after digit 3, upper digits must keep the snapshot
    for (int k = 0; k < 8; k++)
      add((k < 4) ? 32'h1234_5678 : 32'hFFFF_FFFF, 8'h00, 1'b0, 1'b1, anode(k), hs(8 - k), 1'b1);
    // frame C: all F, decimal point on digit 2
    for (int k = 0; k < 8; k++) add(32'hFFFF_FFFF, 8'h04, 1'b0, 1'b1, anode(k), hs(15), (k != 2));
    // frame D: leading-zero blanking of 0000_00A0
    for (int k = 0; k < 8; k++)
      add(32'h0000_00A0, 8'h00, 1'b1, 1'b1, anode(k),
          (k == 0) ? hs(0) : (k == 1) ? hs(10) : 7'h7F, 1'b1);
    // frame E: zero value; blank_lz drops mid-frame but the latched mask holds
    for (int k = 0; k < 8; k++)
      add(32'h0, 8'h00, (k < 3), 1'b1, anode(k), (k == 0) ? hs(0) : 7'h7F, 1'b1);
    // frame F: disabled for a whole frame
    for (int k = 0; k < 8; k++) add(32'h1234_5678, 8'h00, 1'b0, 1'b0, 8'hFF, 7'h7F, 1'b1);
    // frame G: enabled again in phase, one dark slot at digit 3
    for (int k = 0; k < 8; k++)
      add(32'h1234_5678, 8'h00, 1'b0, (k != 3), (k == 3) ? 8'hFF : anode(k),
          (k == 3) ? 7'h7F : hs(8 - k), 1'b1);

    // asynchronous reset asserted mid-cycle
    #2 rst_n = 1'b0;
    #1 check("reset_async", 8'hFF, 7'h7F, 1'b1);
    repeat (3) @(negedge clk);
    check("reset_hold", 8'hFF, 7'h7F, 1'b1);
    rst_n = 1'b1;

    prev.an = 8'hFF; prev.seg = 7'h7F; prev.p = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      value = vecs[i].value;
      dp    = vecs[i].dp;
      blz   = vecs[i].blz;
      en    = vecs[i].en;
      for (int c = 0; c < HMS - 1; c++) begin
        @(negedge clk);
        check($sformatf("hold_%0d_%0d", i, c), prev.an, prev.seg, prev.p);
      end
      @(negedge clk);
      check($sformatf("slot_%0d", i), vecs[i].an, vecs[i].seg, vecs[i].p);
      prev = vecs[i];
    end

    // reset in the middle of a lit digit must darken the display without a clock edge
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("reset_midscan", 8'hFF, 7'h7F, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    value = 32'h0000_0003;
    blz   = 1'b0;
    en    = 1'b1;
    repeat (HMS) @(negedge clk);
    check("after_rereset", 8'hFE, hs(3), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
